// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: ALU control codes, execute FSM encoding and width defaults
package mips_alu_pkg;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ANDI = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDI = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LW   = 4'b1000;
    localparam logic [3:0] ALU_SW   = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_JAL  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_JR   = 4'b1111;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_execute_unit_if.sv
// alu_execute_unit_if: operation request and result buffer handshake bundle
interface alu_execute_unit_if #(
    parameter int DATA_W  = mips_alu_pkg::DATA_W,
    parameter int SHAMT_W = mips_alu_pkg::SHAMT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_op;
    logic               jump_register;
    logic [DATA_W-1:0]  src_a;
    logic [DATA_W-1:0]  src_b;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  pc_plus4;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  result;
    logic               zero;
    logic               branch_taken;
    logic               jr_taken;
    logic [DATA_W-1:0]  jr_target;
    logic               mem_read;
    logic               mem_write;
    logic               illegal_op;
    modport slave (
        input  in_valid, alu_op, jump_register, src_a, src_b, shamt, pc_plus4, out_ready,
        output in_ready, out_valid, result, zero, branch_taken, jr_taken, jr_target,
               mem_read, mem_write, illegal_op
    );
    modport master (
        output in_valid, alu_op, jump_register, src_a, src_b, shamt, pc_plus4, out_ready,
        input  in_ready, out_valid, result, zero, branch_taken, jr_taken, jr_target,
               mem_read, mem_write, illegal_op
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: one-bit-per-cycle left shifter; done flags the cycle of the final shift
module alu_serial_shifter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DATA_W-1:0]  din,
    input  logic [SHAMT_W-1:0] amount,
    output logic [DATA_W-1:0]  shifted,
    output logic               done
);
    logic [DATA_W-1:0]  acc;
    logic [SHAMT_W-1:0] cnt;
    assign shifted = {acc[DATA_W-2:0], 1'b0};
    assign done    = cnt == SHAMT_W'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= din;
            cnt <= amount;
        end else if (cnt != '0) begin
            acc <= shifted;
            cnt <= cnt - SHAMT_W'(1);
        end
    end
endmodule

// File: rtl/alu_execute_unit.sv
// alu_execute_unit: execute stage with serial sll and a single-entry result buffer
module alu_execute_unit #(
    parameter int DATA_W  = mips_alu_pkg::DATA_W,
    parameter int SHAMT_W = mips_alu_pkg::SHAMT_W
) (
    input logic clk,
    input logic reset,
    alu_execute_unit_if.slave bus
);
    import mips_alu_pkg::*;
    state_t state, state_d;
    logic accept, serial, sh_done;
    logic [DATA_W-1:0] sum, diff, op_result, sh_result, result_q, jr_target_q;
    logic op_branch, op_jr, op_rd, op_wr, op_ill;
    logic zero_q, branch_q, jr_q, rd_q, wr_q, ill_q;
    assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign serial       = bus.alu_op == ALU_SLL && bus.shamt != '0;
    assign sum          = bus.src_a + bus.src_b;
    assign diff         = bus.src_a - bus.src_b;
    alu_serial_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (accept && serial),
        .din     (bus.src_b),
        .amount  (bus.shamt),
        .shifted (sh_result),
        .done    (sh_done)
    );
    always_comb begin
        op_result = '0;
        op_branch = 1'b0;
        op_jr     = 1'b0;
        op_rd     = 1'b0;
        op_wr     = 1'b0;
        op_ill    = 1'b0;
        case (bus.alu_op)
            ALU_AND, ALU_ANDI: op_result = bus.src_a & bus.src_b;
            ALU_ADD, ALU_ADDI: op_result = sum;
            // Only the shamt==0 case uses this directly; longer shifts finish in the shifter
            ALU_SLL: op_result = bus.src_b;
            ALU_SLT: op_result = DATA_W'($signed(bus.src_a) < $signed(bus.src_b));
            ALU_LW: begin
                op_result = sum;
                op_rd     = 1'b1;
            end
            ALU_SW: begin
                op_result = sum;
                op_wr     = 1'b1;
            end
            ALU_BEQ: begin
                op_result = diff;
                op_branch = diff == '0;
            end
            ALU_JAL: op_result = bus.pc_plus4;
            ALU_NOR: op_result = ~(bus.src_a | bus.src_b);
            ALU_JR: begin
                op_jr  = bus.jump_register;
                op_ill = !bus.jump_register;
            end
            default: op_ill = 1'b1;
        endcase
    end
    always_comb begin
        state_d = accept ? (serial ? SHIFT : DONE)
                : (state == SHIFT && sh_done) ? DONE
                : (state == DONE && bus.out_ready) ? IDLE
                : state;
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            jr_target_q <= '0;
            zero_q      <= 1'b0;
            branch_q    <= 1'b0;
            jr_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else if (accept) begin
            result_q    <= op_result;
            jr_target_q <= bus.src_a;
            zero_q      <= op_result == '0;
            branch_q    <= op_branch;
            jr_q        <= op_jr;
            rd_q        <= op_rd;
            wr_q        <= op_wr;
            ill_q       <= op_ill;
        end else if (state == SHIFT && sh_done) begin
            result_q <= sh_result;
            zero_q   <= sh_result == '0;
        end
    end
    assign bus.out_valid    = state == DONE;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.jr_target    = jr_target_q;
    assign bus.branch_taken = branch_q && bus.out_valid;
    assign bus.jr_taken     = jr_q && bus.out_valid;
    assign bus.mem_read     = rd_q && bus.out_valid;
    assign bus.mem_write    = wr_q && bus.out_valid;
    assign bus.illegal_op   = ill_q && bus.out_valid;
endmodule
